// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: multi-bank runtime-writable sprite palette with a fixed 2-cycle lookup.
// Optional hit-flash overlay enabled by defining SPRITE_PALETTE_FLASH_EN.
module sprite_palette_bank #(
    parameter int INDEX_W      = 3,
    parameter int BANKS        = 4,
    parameter int FLASH_FRAMES = 16,
    localparam int BANK_W      = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [BANK_W-1:0]  bank_req,
    input  logic               bank_req_vld,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [11:0]        wr_rgb,
    input  logic               pix_vld,
    input  logic [INDEX_W-1:0] pix_index,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               out_vld,
    output logic               transparent,
    output logic [BANK_W-1:0]  active_bank,
    input  logic               flash_req
);

    localparam int ENTRIES = 2 ** INDEX_W;
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(BANKS);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    function automatic logic [11:0] reset_entry(input int unsigned bank, input int unsigned idx);
        if (bank != 0) return '0;
        case (idx)
            1:       return 12'h0E0;
            2:       return 12'hDA9;
            3:       return 12'h421;
            4:       return 12'hB20;
            5:       return 12'h060;
            6:       return 12'hEEE;
            7:       return 12'h766;
            default: return '0;
        endcase
    endfunction

    logic [11:0]        pal [BANKS][ENTRIES];
    logic               wr_ok;
    logic               req_ok;
    logic               s1_vld;
    logic [INDEX_W-1:0] s1_index;
    logic [BANK_W-1:0]  s1_bank;
    logic [11:0]        lookup_rgb;
    logic               flash_on;
    state_t             state, state_next;
    logic [BANK_W-1:0]  pending, pending_next, active_next;

    always_comb begin
        wr_ok  = wr_en && ({1'b0, wr_bank} < BANK_LIMIT);
        req_ok = bank_req_vld && ({1'b0, bank_req} < BANK_LIMIT);
    end

    // Palette storage; a write and a lookup of the same entry on one edge returns the old value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                for (int unsigned e = 0; e < ENTRIES; e++) begin
                    pal[b][e] <= reset_entry(b, e);
                end
            end
        end else if (wr_ok) begin
            pal[wr_bank][wr_index] <= wr_rgb;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_vld   <= 1'b0;
            s1_index <= '0;
            s1_bank  <= '0;
        end else begin
            s1_vld <= pix_vld;
            if (pix_vld) begin
                s1_index <= pix_index;
                s1_bank  <= active_bank;
            end
        end
    end

`ifdef SPRITE_PALETTE_FLASH_EN
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    logic [FLASH_W-1:0] flash_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flash_cnt <= '0;
        end else if (flash_req) begin
            flash_cnt <= FLASH_W'(FLASH_FRAMES);
        end else if (frame_start && flash_cnt != '0) begin
            flash_cnt <= flash_cnt - FLASH_W'(1);
        end
    end

    // An odd count is necessarily non-zero, so bit 0 alone selects the flash frames.
    always_comb flash_on = flash_cnt[0];
`else
    logic unused_flash_req;
    always_comb begin
        unused_flash_req = flash_req;
        flash_on         = 1'b0;
    end
`endif

    always_comb begin
        lookup_rgb = pal[s1_bank][s1_index];
        if (flash_on && s1_index != '0) lookup_rgb = 12'hEEE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_vld              <= 1'b0;
            transparent          <= 1'b0;
            {red, green, blue}   <= '0;
        end else begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                {red, green, blue} <= lookup_rgb;
                transparent        <= (s1_index == '0);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            pending     <= '0;
            active_bank <= '0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            active_bank <= active_next;
        end
    end

    // A request arriving with frame_start bypasses the pending slot and swaps immediately.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        active_next  = active_bank;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    if (frame_start) begin
                        active_next = bank_req;
                    end else begin
                        pending_next = bank_req;
                        state_next   = PENDING;
                    end
                end
            end
            PENDING: begin
                if (frame_start) begin
                    active_next = req_ok ? bank_req : pending;
                    state_next  = IDLE;
                end else if (req_ok) begin
                    pending_next = bank_req;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: directed vector table, hand sequences and
// randomized traffic compared against a behavioural palette model.
module tb_sprite_palette_bank;

    localparam int INDEX_W = 3;
    localparam int BANKS   = 4;
    localparam int BANK_W  = 2;
`ifdef SPRITE_PALETTE_FLASH_EN
    localparam int FLASH_FRAMES = 4;
    localparam bit FLASH        = 1'b1;
`else
    localparam int FLASH_FRAMES = 16;
    localparam bit FLASH        = 1'b0;
`endif

    logic               Clk = 1'b0;
    logic               Reset;
    logic               frame_start;
    logic [BANK_W-1:0]  bank_req;
    logic               bank_req_vld;
    logic               wr_en;
    logic [BANK_W-1:0]  wr_bank;
    logic [INDEX_W-1:0] wr_index;
    logic [11:0]        wr_rgb;
    logic               pix_vld;
    logic [INDEX_W-1:0] pix_index;
    logic               flash_req;
    logic [3:0]         red, green, blue;
    logic               out_vld, transparent;
    logic [BANK_W-1:0]  active_bank;

    logic [3:0]         unused_d3_red, unused_d3_green, unused_d3_blue;
    logic               unused_d3_vld, unused_d3_transparent;
    logic [1:0]         d3_active_bank;

    always #5 Clk = ~Clk;

    sprite_palette_bank #(.INDEX_W(INDEX_W), .BANKS(BANKS), .FLASH_FRAMES(FLASH_FRAMES)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .bank_req(bank_req),
        .bank_req_vld(bank_req_vld), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
        .wr_rgb(wr_rgb), .pix_vld(pix_vld), .pix_index(pix_index), .red(red), .green(green),
        .blue(blue), .out_vld(out_vld), .transparent(transparent), .active_bank(active_bank),
        .flash_req(flash_req)
    );

    // Three-bank instance: bank number 3 is out of range and must be ignored.
    sprite_palette_bank #(.INDEX_W(INDEX_W), .BANKS(3), .FLASH_FRAMES(FLASH_FRAMES)) dut3 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .bank_req(bank_req),
        .bank_req_vld(bank_req_vld), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
        .wr_rgb(wr_rgb), .pix_vld(pix_vld), .pix_index(pix_index), .red(unused_d3_red),
        .green(unused_d3_green), .blue(unused_d3_blue), .out_vld(unused_d3_vld),
        .transparent(unused_d3_transparent), .active_bank(d3_active_bank),
        .flash_req(flash_req)
    );

    int vectors = 0;
    int misc    = 0;

    // Behavioural model: palette contents, active bank, optional pending request,
    // pixels waiting for lookup, held outputs and flash frame counter.
    logic [11:0]  m_pal [BANKS][8];
    int unsigned  m_active;
    bit           m_pend_v;
    int unsigned  m_pend;
    typedef struct {
        int unsigned idx;
        int unsigned bank;
    } pix_t;
    pix_t         inflight[$];
    logic [11:0]  m_rgb;
    bit           m_vld, m_transp;
    int unsigned  m_flash;

    function automatic void model_reset();
        logic [11:0] def [8];
        def = '{12'h000, 12'h0E0, 12'hDA9, 12'h421, 12'hB20, 12'h060, 12'hEEE, 12'h766};
        for (int b = 0; b < BANKS; b++)
            for (int e = 0; e < 8; e++)
                m_pal[b][e] = (b == 0) ? def[e] : 12'h000;
        m_active = 0; m_pend_v = 0; m_pend = 0;
        inflight.delete();
        m_rgb = 12'h000; m_vld = 0; m_transp = 0; m_flash = 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        pix_t p;
        m_vld = 0;
        if (inflight.size() > 0) begin
            p        = inflight.pop_front();
            m_vld    = 1;
            m_transp = (p.idx == 0);
            m_rgb    = m_pal[p.bank][p.idx];
            if (FLASH && (m_flash % 2 == 1) && p.idx != 0) m_rgb = 12'hEEE;
        end
        if (pix_vld) begin
            p.idx  = pix_index;
            p.bank = m_active;
            inflight.push_back(p);
        end
        if (wr_en && wr_bank < BANKS) m_pal[wr_bank][wr_index] = wr_rgb;
        if (frame_start) begin
            if (bank_req_vld && bank_req < BANKS) m_active = bank_req;
            else if (m_pend_v) m_active = m_pend;
            m_pend_v = 0;
        end else if (bank_req_vld && bank_req < BANKS) begin
            m_pend_v = 1;
            m_pend   = bank_req;
        end
        if (flash_req) m_flash = FLASH_FRAMES;
        else if (frame_start && m_flash > 0) m_flash = m_flash - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        frame_start = 0; bank_req = '0; bank_req_vld = 0; wr_en = 0; wr_bank = '0;
        wr_index = '0; wr_rgb = '0; pix_vld = 0; pix_index = '0; flash_req = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check("out_vld", 32'(out_vld), 32'(m_vld));
        check("rgb", 32'({red, green, blue}), 32'(m_rgb));
        check("transparent", 32'(transparent), 32'(m_transp));
        check("active_bank", 32'(active_bank), m_active);
    endtask

    task automatic apply_reset();
        Reset = 1;
        idle_inputs();
        model_reset();
        #2;
        check("reset_out_vld", 32'(out_vld), 0);
        check("reset_rgb", 32'({red, green, blue}), 0);
        check("reset_transparent", 32'(transparent), 0);
        check("reset_active_bank", 32'(active_bank), 0);
        check("reset_d3_active_bank", 32'(d3_active_bank), 0);
        @(posedge Clk);
        #1;
        Reset = 0;
    endtask

    typedef struct {
        bit pv; logic [2:0] pi;
        bit we; logic [1:0] wb; logic [2:0] wi; logic [11:0] wrgb;
        bit bv; logic [1:0] br; bit fs;
        bit ev; logic [11:0] ergb; bit et; logic [1:0] eb;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit pv, int pi, bit we, int wb, int wi, int wrgb,
                                bit bv, int br, bit fs, bit ev, int ergb, bit et, int eb);
        vec_t v;
        v.pv = pv; v.pi = 3'(pi); v.we = we; v.wb = 2'(wb); v.wi = 3'(wi); v.wrgb = 12'(wrgb);
        v.bv = bv; v.br = 2'(br); v.fs = fs;
        v.ev = ev; v.ergb = 12'(ergb); v.et = et; v.eb = 2'(eb);
        return v;
    endfunction

    initial begin
        idle_inputs();
        Reset = 1;
        #1;
        //               pv pi we wb wi wrgb   bv br fs | ev ergb    et eb
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,     0, 0, 0,   0, 12'h000, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0,     0, 0, 0,   1, 12'h0E0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,     0, 0, 0,   1, 12'hDA9, 0, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0,     0, 0, 0,   1, 12'h421, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0,     0, 0, 0,   1, 12'hB20, 0, 0));
        tbl.push_back(mk(1, 6, 0, 0, 0, 0,     0, 0, 0,   1, 12'h060, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,     0, 0, 0,   1, 12'hEEE, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 0,   1, 12'h766, 0, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0,     0, 0, 0,   1, 12'h000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   1, 12'hB20, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   0, 12'hB20, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0,     0, 0, 0,   0, 12'hB20, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 2, 'hF00, 0, 0, 0,   1, 12'hDA9, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   1, 12'hF00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   0, 12'hF00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,     1, 1, 0,   0, 12'hF00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,     0, 0, 0,   1, 12'h0E0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,     0, 0, 1,   1, 12'h0E0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,     0, 0, 0,   1, 12'h0E0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   1, 12'h000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 2, 0,   0, 12'h000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 3, 0,   0, 12'h000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 1,   0, 12'h000, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     1, 2, 1,   0, 12'h000, 0, 2));
        tbl.push_back(mk(1, 5, 1, 2, 5, 'hABC, 0, 0, 0,   0, 12'h000, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   1, 12'hABC, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   0, 12'hABC, 0, 2));

        apply_reset();

        foreach (tbl[i]) begin
            pix_vld = tbl[i].pv; pix_index = tbl[i].pi;
            wr_en = tbl[i].we; wr_bank = tbl[i].wb; wr_index = tbl[i].wi; wr_rgb = tbl[i].wrgb;
            bank_req_vld = tbl[i].bv; bank_req = tbl[i].br; frame_start = tbl[i].fs;
            tick();
            check("tbl_out_vld", 32'(out_vld), 32'(tbl[i].ev));
            check("tbl_rgb", 32'({red, green, blue}), 32'(tbl[i].ergb));
            check("tbl_transparent", 32'(transparent), 32'(tbl[i].et));
            check("tbl_active_bank", 32'(active_bank), 32'(tbl[i].eb));
        end

        // Reset with a pixel in flight: the pixel must never appear, palette returns to defaults.
        idle_inputs();
        pix_vld = 1; pix_index = 3'd3;
        tick();
        apply_reset();
        tick();
        check("reset_drop_vld", 32'(out_vld), 0);
        pix_vld = 1; pix_index = 3'd2;
        tick();
        pix_vld = 0;
        tick();
        check("reset_palette_restored", 32'({red, green, blue}), 32'h0DA9);

        // Out-of-range bank requests on the three-bank instance.
        bank_req_vld = 1; bank_req = 2'd3; frame_start = 1;
        tick();
        check("d3_ignore_same_edge", 32'(d3_active_bank), 0);
        frame_start = 0;
        tick();
        bank_req_vld = 0; frame_start = 1;
        tick();
        check("d3_ignore_pending", 32'(d3_active_bank), 0);
        bank_req_vld = 1; bank_req = 2'd2; frame_start = 0;
        tick();
        bank_req_vld = 0; frame_start = 1;
        tick();
        check("d3_accept_2", 32'(d3_active_bank), 2);
        idle_inputs();

`ifdef SPRITE_PALETTE_FLASH_EN
        apply_reset();
        flash_req = 1;
        tick();
        flash_req = 0;
        for (int f = 0; f < 6; f++) begin
            pix_vld = 1; pix_index = 3'd4;
            repeat (3) tick();
            pix_vld = 1; pix_index = 3'd0;
            tick();
            pix_vld = 0; frame_start = 1;
            tick();
            frame_start = 0;
        end
`endif

        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            pix_vld      = ($urandom_range(0, 3) != 0);
            pix_index    = 3'($urandom);
            wr_en        = ($urandom_range(0, 5) == 0);
            wr_bank      = 2'($urandom);
            wr_index     = 3'($urandom);
            wr_rgb       = 12'($urandom);
            bank_req_vld = ($urandom_range(0, 9) == 0);
            bank_req     = 2'($urandom);
            frame_start  = ($urandom_range(0, 19) == 0);
            flash_req    = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
